// File: rtl/pc_ctrl_pkg.sv
// Shared encodings for the next-PC sequencer: mux selects, decoder classes,
// sequencer states and exception cause codes.
package pc_ctrl_pkg;

    localparam logic [2:0] PCSRC_PC4    = 3'b000;
    localparam logic [2:0] PCSRC_BRANCH = 3'b001;
    localparam logic [2:0] PCSRC_JUMP   = 3'b010;
    localparam logic [2:0] PCSRC_REG    = 3'b011;
    localparam logic [2:0] PCSRC_EXC    = 3'b100;

    localparam logic [2:0] CLS_SEQ     = 3'b000;
    localparam logic [2:0] CLS_BEQ     = 3'b001;
    localparam logic [2:0] CLS_BNE     = 3'b010;
    localparam logic [2:0] CLS_JUMP    = 3'b011;
    localparam logic [2:0] CLS_JR      = 3'b100;
    localparam logic [2:0] CLS_ARITH   = 3'b101;
    localparam logic [2:0] CLS_ILLEGAL = 3'b110;

    localparam logic CAUSE_ILLEGAL  = 1'b0;
    localparam logic CAUSE_OVERFLOW = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_EXC_SAVE,
        ST_EXC_WAIT,
        ST_EXC_LOAD,
        ST_DONE
    } state_t;

endpackage

// File: rtl/pc_source_ctrl.sv
// Multicycle next-PC sequencer: sole owner of the PC source selector and the
// PC/EPC write enables, stepping fetch, decode, execute and the exception path.
module pc_source_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int EXC_WAIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       mem_ready,
    input  logic [2:0] instr_class,
    input  logic       alu_zero,
    input  logic       alu_overflow,
    output logic [2:0] pc_source,
    output logic       pc_write,
    output logic       epc_write,
    output logic       exc_cause,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] WAIT_LAST = 4'(EXC_WAIT_CYCLES - 1);

    state_t     state;
    state_t     next_state;
    logic [2:0] class_q;
    logic [3:0] wait_cnt;
    logic       cause_load;
    logic       cause_next;

    // The cause is captured on the EXEC exit edge so it is already valid
    // while EPC is being written in EXC_SAVE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            class_q   <= CLS_SEQ;
            wait_cnt  <= 4'd0;
            exc_cause <= 1'b0;
        end else begin
            state <= next_state;
            if (state == ST_DECODE) begin
                class_q <= instr_class;
            end
            if (state == ST_EXC_WAIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end else begin
                wait_cnt <= 4'd0;
            end
            if (cause_load) begin
                exc_cause <= cause_next;
            end
        end
    end

    always_comb begin
        next_state = state;
        pc_write   = 1'b0;
        pc_source  = PCSRC_PC4;
        epc_write  = 1'b0;
        cause_load = 1'b0;
        cause_next = exc_cause;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (mem_ready) begin
                    pc_write   = 1'b1;
                    pc_source  = PCSRC_PC4;
                    next_state = ST_DECODE;
                end
            end
            ST_DECODE: begin
                next_state = ST_EXEC;
            end
            ST_EXEC: begin
                next_state = ST_DONE;
                unique case (class_q)
                    CLS_SEQ: ;
                    CLS_BEQ: begin
                        if (alu_zero) begin
                            pc_write  = 1'b1;
                            pc_source = PCSRC_BRANCH;
                        end
                    end
                    CLS_BNE: begin
                        if (!alu_zero) begin
                            pc_write  = 1'b1;
                            pc_source = PCSRC_BRANCH;
                        end
                    end
                    CLS_JUMP: begin
                        pc_write  = 1'b1;
                        pc_source = PCSRC_JUMP;
                    end
                    CLS_JR: begin
                        pc_write  = 1'b1;
                        pc_source = PCSRC_REG;
                    end
                    CLS_ARITH: begin
                        if (alu_overflow) begin
                            next_state = ST_EXC_SAVE;
                            cause_load = 1'b1;
                            cause_next = CAUSE_OVERFLOW;
                        end
                    end
                    default: begin
                        next_state = ST_EXC_SAVE;
                        cause_load = 1'b1;
                        cause_next = CAUSE_ILLEGAL;
                    end
                endcase
            end
            ST_EXC_SAVE: begin
                epc_write  = 1'b1;
                next_state = ST_EXC_WAIT;
            end
            ST_EXC_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    next_state = ST_EXC_LOAD;
                end
            end
            ST_EXC_LOAD: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_EXC;
                next_state = ST_DONE;
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule

// File: doc/pc_source_ctrl.md
# pc_source_ctrl

Multicycle next-PC sequencer for the CPU datapath. Per instruction it drives the 3-bit PC source mux selector plus the PC and EPC write enables: PC+4 after fetch, then branch target, jump target, register target or exception vector depending on the decoded class and ALU flags. It sits between the main control unit (start/done handshake) and the PC/EPC registers, and is the only owner of the PC source selector.

## Interface
- `EXC_WAIT_CYCLES`, default 2: cycles spent waiting for the exception-vector byte load. Legal range 1..15.
- `clk` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: begin one instruction. Sampled only in IDLE.
- `mem_ready` in 1: instruction fetch complete. Sampled only in FETCH.
- `instr_class` in 3: decoder class, sampled in DECODE. 000 SEQ, 001 BEQ, 010 BNE, 011 JUMP (j/jal), 100 JR, 101 ARITH (overflow-checked), 110 ILLEGAL, 111 treated as ILLEGAL.
- `alu_zero` in 1: branch comparison result, sampled in EXEC.
- `alu_overflow` in 1: arithmetic overflow, sampled in EXEC for ARITH only.
- `pc_source` out 3: mux selector. 000 PC+4, 001 ALUOut (branch target), 010 jump target, 011 register A (jr), 100 exception vector.
- `pc_write` out 1: PC register load enable.
- `epc_write` out 1: EPC register load enable.
- `exc_cause` out 1: 0 illegal opcode, 1 overflow. Held from EXC_SAVE until the next EXC_SAVE.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at instruction end.

## Operation
- States and transitions:
  - IDLE: go to FETCH when `start`=1.
  - FETCH: stay until `mem_ready`=1. In that cycle assert `pc_write`=1 with `pc_source`=000, then go to DECODE.
  - DECODE: one cycle; register `instr_class`. Go to EXEC.
  - EXEC: one cycle; action depends on class.
  - EXC_SAVE: `epc_write`=1, latch `exc_cause`. Go to EXC_WAIT.
  - EXC_WAIT: count EXC_WAIT_CYCLES, then go to EXC_LOAD.
  - EXC_LOAD: `pc_write`=1, `pc_source`=100. Go to DONE.
  - DONE: `done`=1. Go to IDLE.
- EXEC actions:
  - SEQ: no write, go to DONE.
  - BEQ: if `alu_zero`=1, `pc_write`=1 with `pc_source`=001. Go to DONE.
  - BNE: same as BEQ, but the write occurs when `alu_zero`=0.
  - JUMP: `pc_write`=1, `pc_source`=010. Go to DONE.
  - JR: `pc_write`=1, `pc_source`=011. Go to DONE.
  - ARITH: if `alu_overflow`=1 go to EXC_SAVE with cause 1, else go to DONE. `alu_overflow` is ignored for all other classes.
  - ILLEGAL and 111: go to EXC_SAVE with cause 0.
- `pc_source` is 000 whenever `pc_write`=0. It never holds a value of 101..111.
- `pc_write` and `epc_write` are never high in the same cycle.
- `start` while `busy`=1 is ignored; it is not queued.
- Reset values: state IDLE; `pc_source`=000; `pc_write`, `epc_write`, `exc_cause`, `busy`, `done` all 0. Reset takes effect immediately, mid-instruction included. The wait counter clears to 0.

## Timing
- All outputs are decoded from the registered state plus the sampled inputs of the current cycle (Mealy for `pc_write`/`pc_source` in FETCH and EXEC). No output depends combinationally on `start`.
- Latencies, with `mem_ready` already high, counting from the edge that samples `start`:
  - PC+4 write in cycle 1.
  - Branch, jump or jr write in cycle 3.
  - `done` in cycle 4.
- Each extra cycle of `mem_ready` low adds exactly one cycle to every latency.
- Exception path: EXC_SAVE in cycle 4, EXC_WAIT cycles 5..4+N, EXC_LOAD in cycle 5+N, `done` in cycle 6+N, where N = EXC_WAIT_CYCLES.
- Back-to-back: `start` held high in the DONE cycle is not seen, because DONE does not sample it. It is seen on the first IDLE cycle, giving a minimum of 5 cycles per SEQ instruction.

## Structure
- Shared package `pc_ctrl_pkg` holds:
  - `pc_source` encodings (PCSRC_PC4, PCSRC_BRANCH, PCSRC_JUMP, PCSRC_REG, PCSRC_EXC);
  - `instr_class` encodings;
  - the state enum;
  - the cause codes.
- Single module, no sub-modules. The wait counter is 4 bits, inline.
- The PC source mux itself stays in the datapath, and `pc_source` connects directly to its selector.

## Test plan
- Reset mid-EXC_WAIT: assert `reset` low asynchronously in that state -> all outputs 0 immediately; state is IDLE after release.
- SEQ with `mem_ready` delayed 3 cycles -> single `pc_write` with 000 in cycle 4, `done` in cycle 7, no other writes.
- BEQ with `alu_zero`=1 -> `pc_write` with 001 in cycle 3. BEQ with `alu_zero`=0 -> only the cycle-1 PC+4 write. BNE mirrored.
- JUMP then JR issued back-to-back -> 010 write in cycle 3, `done` in cycle 4; next `start` accepted in cycle 5, 011 write 3 cycles later. `start` pulsed in cycle 2 -> ignored.
- ARITH with `alu_overflow`=1, EXC_WAIT_CYCLES=2 -> `epc_write` in cycle 4, `exc_cause`=1, 100 write in cycle 7, `done` in cycle 8. ARITH with `alu_overflow`=0 -> no exception, `done` in cycle 4.
- Class 110 and class 111 -> `exc_cause`=0, `epc_write` then vector write. `pc_write` and `epc_write` are never high together across the whole run.
